// File: rtl/decoder_seq_n_if.sv
// Command/output bundle for decoder_seq_n: valid/ready command port plus the
// registered one-hot output and its status flags.
interface decoder_seq_n_if #(
  parameter int SEL_W   = 3,
  parameter int NUM_OUT = 8,
  parameter int DWELL_W = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [SEL_W-1:0]   sel;
  logic [1:0]         mode;
  logic [DWELL_W-1:0] dwell;
  logic               stop;
  logic [NUM_OUT-1:0] out;
  logic               out_valid;
  logic               busy;
  logic               err;

  modport master (
    output in_valid, sel, mode, dwell, stop,
    input  in_ready, out, out_valid, busy, err
  );

  modport slave (
    input  in_valid, sel, mode, dwell, stop,
    output in_ready, out, out_valid, busy, err
  );
endinterface

// File: rtl/decoder_seq_n.sv
// Registered binary-to-one-hot decoder with DIRECT/PULSE/SCAN/RING modes.
// Define DEC_RANGE_CHK_EN to get a one-cycle err flag on out-of-range commands.
module decoder_seq_n #(
  parameter int SEL_W   = 3,
  parameter int NUM_OUT = 8,
  parameter int DWELL_W = 8
) (
  input logic clk,
  input logic rst,
  decoder_seq_n_if.slave bus
);

  typedef enum logic [1:0] {IDLE, HOLD, PULSE, SCAN} state_t;

  localparam int LAST_I = NUM_OUT - 1;
  localparam logic [SEL_W-1:0] LAST = LAST_I[SEL_W-1:0];

  state_t             state, state_n;
  logic               wrap, wrap_n;
  logic [SEL_W-1:0]   idx, idx_n;
  logic [DWELL_W-1:0] cnt, cnt_n;
  logic [DWELL_W-1:0] dwell_r, dwell_n;
  logic [NUM_OUT-1:0] out_r, out_n;
  logic [NUM_OUT-1:0] sel_oh;
  logic               accept;
  logic               in_range;

  assign bus.in_ready  = (state == IDLE || state == HOLD) && !bus.stop;
  assign bus.busy      = (state == PULSE || state == SCAN);
  assign bus.out       = out_r;
  assign bus.out_valid = |out_r;
  assign accept        = bus.in_valid && bus.in_ready;
  assign in_range      = (bus.sel <= LAST);

  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      sel_oh[i] = (bus.sel == SEL_W'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      wrap    <= 1'b0;
      idx     <= '0;
      cnt     <= '0;
      dwell_r <= '0;
      out_r   <= '0;
    end else begin
      state   <= state_n;
      wrap    <= wrap_n;
      idx     <= idx_n;
      cnt     <= cnt_n;
      dwell_r <= dwell_n;
      out_r   <= out_n;
    end
  end

  // RING is SCAN with wrap set; a step ends when cnt reaches zero.
  always_comb begin
    state_n = state;
    wrap_n  = wrap;
    idx_n   = idx;
    cnt_n   = cnt;
    dwell_n = dwell_r;
    out_n   = out_r;
    case (state)
      IDLE, HOLD: begin
        if (bus.stop) begin
          out_n   = '0;
          state_n = IDLE;
        end else if (accept) begin
          if (!in_range) begin
            out_n   = '0;
            state_n = IDLE;
          end else begin
            out_n   = sel_oh;
            idx_n   = bus.sel;
            cnt_n   = bus.dwell;
            dwell_n = bus.dwell;
            wrap_n  = (bus.mode == 2'b11);
            case (bus.mode)
              2'b00: begin
                state_n = HOLD;
                cnt_n   = '0;
              end
              2'b01:   state_n = PULSE;
              default: state_n = SCAN;
            endcase
          end
        end
      end
      PULSE, SCAN: begin
        if (bus.stop) begin
          out_n   = '0;
          cnt_n   = '0;
          state_n = IDLE;
        end else if (cnt != '0) begin
          cnt_n = cnt - DWELL_W'(1);
        end else if (state == SCAN && idx != LAST) begin
          idx_n = idx + SEL_W'(1);
          out_n = out_r << 1;
          cnt_n = dwell_r;
        end else if (state == SCAN && wrap) begin
          idx_n = '0;
          out_n = NUM_OUT'(1);
          cnt_n = dwell_r;
        end else begin
          out_n   = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef DEC_RANGE_CHK_EN
  logic err_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else begin
      err_r <= accept && !in_range;
    end
  end

  assign bus.err = err_r;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_decoder_seq_n.sv
// Scoreboard bench for decoder_seq_n: an 8-output instance driven through the
// mode sequences, plus a 6-output instance for the out-of-range index path.
module tb_decoder_seq_n;

  typedef struct {
    logic [7:0] out;
    logic       busy;
    logic       ready;
  } exp_t;

`ifdef DEC_RANGE_CHK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t expq[$];

  decoder_seq_n_if #(.SEL_W(3), .NUM_OUT(8), .DWELL_W(8)) bus8 ();
  decoder_seq_n_if #(.SEL_W(3), .NUM_OUT(6), .DWELL_W(8)) bus6 ();

  decoder_seq_n #(.SEL_W(3), .NUM_OUT(8), .DWELL_W(8)) dut8 (
    .clk(clk), .rst(rst), .bus(bus8)
  );

  decoder_seq_n #(.SEL_W(3), .NUM_OUT(6), .DWELL_W(8)) dut6 (
    .clk(clk), .rst(rst), .bus(bus6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural expectation for n cycles following the accept edge.
  task automatic pushModel(input int s, input int m, input int d, input int n);
    int   ix = s;
    int   c = d;
    bit   active = 1'b1;
    exp_t e;
    for (int i = 0; i < n; i++) begin
      if (active) begin
        e.out   = 8'(1 << ix);
        e.busy  = (m != 0);
        e.ready = (m == 0);
      end else begin
        e.out   = 8'h00;
        e.busy  = 1'b0;
        e.ready = 1'b1;
      end
      expq.push_back(e);
      if (active && m != 0) begin
        if (c > 0) c--;
        else if (m == 1) active = 1'b0;
        else if (ix < 7) begin ix++; c = d; end
        else if (m == 3) begin ix = 0; c = d; end
        else active = 1'b0;
      end
    end
  endtask

  task automatic pushIdle();
    exp_t e;
    e.out   = 8'h00;
    e.busy  = 1'b0;
    e.ready = 1'b1;
    expq.push_back(e);
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound && expq.size() != 0; i++) begin
      @(negedge clk);
      #2;
    end
    if (expq.size() != 0) begin
      checkOutput("drain_timeout", expq.size(), 0);
      expq.delete();
    end
  endtask

  task automatic applyStimulus(input int s, input int m, input int d, input int n);
    bus8.in_valid = 1'b1;
    bus8.sel      = 3'(s);
    bus8.mode     = 2'(m);
    bus8.dwell    = 8'(d);
    pushModel(s, m, d, n);
    @(posedge clk);
    #1 bus8.in_valid = 1'b0;
    drain(n + 4);
  endtask

  task automatic applyStop(input logic withCmd);
    bus8.stop     = 1'b1;
    bus8.in_valid = withCmd;
    bus8.sel      = 3'd4;
    bus8.mode     = 2'b00;
    pushIdle();
    @(posedge clk);
    #1;
    bus8.stop     = 1'b0;
    bus8.in_valid = 1'b0;
    drain(4);
  endtask

  always @(negedge clk) begin
    if (expq.size() != 0) begin
      exp_t e;
      e = expq.pop_front();
      checkOutput("out", 32'(bus8.out), 32'(e.out));
      checkOutput("out_valid", 32'(bus8.out_valid), 32'(e.out != 8'h00));
      checkOutput("busy", 32'(bus8.busy), 32'(e.busy));
      checkOutput("in_ready", 32'(bus8.in_ready), 32'(e.ready));
      checkOutput("err8", 32'(bus8.err), 32'd0);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s, m, d, n;
    rst = 1'b1;
    bus8.in_valid = 1'b0; bus8.sel = '0; bus8.mode = '0; bus8.dwell = '0; bus8.stop = 1'b0;
    bus6.in_valid = 1'b0; bus6.sel = '0; bus6.mode = '0; bus6.dwell = '0; bus6.stop = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("rst_out", 32'(bus8.out), 32'd0);
    checkOutput("rst_valid", 32'(bus8.out_valid), 32'd0);
    checkOutput("rst_busy", 32'(bus8.busy), 32'd0);
    checkOutput("rst_err", 32'(bus8.err), 32'd0);
    checkOutput("rst_ready", 32'(bus8.in_ready), 32'd1);
    #2 rst = 1'b0;

    // Back-to-back DIRECT commands: the new line replaces the old with no gap.
    applyStimulus(5, 0, 0, 1);
    applyStimulus(2, 0, 0, 2);
    applyStimulus(3, 1, 2, 5);
    applyStimulus(6, 2, 0, 3);
    applyStimulus(7, 3, 1, 6);
    applyStop(1'b0);

    applyStimulus(1, 0, 0, 1);
    applyStop(1'b1);

    for (int i = 0; i < 4; i++) begin
      m = $urandom_range(0, 2);
      s = $urandom_range(0, 7);
      d = $urandom_range(0, 2);
      n = (m == 0) ? 2 : (m == 1) ? d + 3 : (8 - s) * (d + 1) + 2;
      applyStimulus(s, m, d, n);
    end

    // Reset pulse in the middle of a scan clears out without a clock edge.
    applyStimulus(0, 2, 3, 3);
    rst = 1'b1;
    #1;
    checkOutput("arst_out", 32'(bus8.out), 32'd0);
    checkOutput("arst_busy", 32'(bus8.busy), 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_ready", 32'(bus8.in_ready), 32'd1);
    checkOutput("post_rst_busy", 32'(bus8.busy), 32'd0);
    checkOutput("post_rst_out", 32'(bus8.out), 32'd0);
    #2;

    bus6.in_valid = 1'b1; bus6.sel = 3'd5; bus6.mode = 2'b00;
    @(posedge clk);
    #1 bus6.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("n6_direct_out", 32'(bus6.out), 32'h20);
    checkOutput("n6_direct_err", 32'(bus6.err), 32'd0);
    #2;
    bus6.in_valid = 1'b1; bus6.sel = 3'd6; bus6.mode = 2'b00;
    @(posedge clk);
    #1 bus6.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("n6_oor_out", 32'(bus6.out), 32'd0);
    checkOutput("n6_oor_err", 32'(bus6.err), 32'(EXP_ERR));
    checkOutput("n6_oor_ready", 32'(bus6.in_ready), 32'd1);
    checkOutput("n6_oor_busy", 32'(bus6.busy), 32'd0);
    @(negedge clk);
    checkOutput("n6_err_clear", 32'(bus6.err), 32'd0);
    #2;
    bus6.in_valid = 1'b1; bus6.sel = 3'd7; bus6.mode = 2'b01; bus6.dwell = 8'd2;
    @(posedge clk);
    #1 bus6.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("n6_oor_pulse_out", 32'(bus6.out), 32'd0);
    checkOutput("n6_oor_pulse_busy", 32'(bus6.busy), 32'd0);
    checkOutput("n6_oor_pulse_err", 32'(bus6.err), 32'(EXP_ERR));

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
